// File: rtl/uart_prog_loader_if.sv
// -----------------------------------------------------------------------------
// uart_prog_loader_if
// Purpose : instruction-memory write bus driven by the UART boot loader.
// Signals : imem_we    - one-cycle write strobe
//           imem_addr  - word address of the current write (ADDR_W bits)
//           imem_wdata - 32-bit word to write
// Modports: master (loader side, drives the bus), slave (memory side).
// -----------------------------------------------------------------------------
interface uart_prog_loader_if #(
   parameter int ADDR_W = 14
);
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport master (output imem_we, output imem_addr, output imem_wdata);
   modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);
endinterface

// File: rtl/uart_prog_loader.sv
// -----------------------------------------------------------------------------
// uart_prog_loader
// Purpose : serial (UART 8N1) boot loader. Receives a 16-bit little-endian word
//           count N followed by N little-endian 32-bit words and writes them to
//           instruction memory at word addresses 0..N-1, holding the CPU in
//           reset for the whole load.
// Ports   : clk      - board clock, all logic on posedge
//           rst_a    - synchronous active-low reset
//           rx       - asynchronous UART receive line, idle high
//           load_req - level; a rising edge starts a load (from IDLE/DONE/ERR)
//           imem     - instruction-memory write bus (master modport)
//           cpu_hold - 1 keeps the CPU in reset
//           done     - load completed, held until next load or reset
//           err      - load failed, held until next load or reset
// Config  : define UART_CSUM_EN to expect a trailing XOR checksum byte over
//           all data bytes; a mismatch ends the load in ERR.
// -----------------------------------------------------------------------------
module uart_prog_loader #(
   parameter int CLK_HZ = 100_000_000,
   parameter int BAUD   = 115200,
   parameter int ADDR_W = 14
) (
   input  logic                clk,
   input  logic                rst_a,
   input  logic                rx,
   input  logic                load_req,
   uart_prog_loader_if.master  imem,
   output logic                cpu_hold,
   output logic                done,
   output logic                err
);
   localparam int CPB   = CLK_HZ / BAUD;
   localparam int HALF  = CPB / 2;
   localparam int CNT_W = $clog2(CPB + 1);
   localparam logic [16:0]     CAP = 17'(2 ** ADDR_W);
   localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;
`ifdef UART_CSUM_EN
   typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_DATA, S_CSUM, S_DONE, S_ERR} st_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_DATA, S_DONE, S_ERR} st_t;
`endif

   // receiver state
   logic             r_rx_p0, r_rx_p1;
   rx_st_t           r_rx_st, w_rx_st_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [2:0]       r_bit, w_bit_nxt;
   logic [7:0]       r_sh, w_sh_nxt;
   logic             w_byte_vld, w_frm_err;
   logic             r_byte_vld, r_frm_err;

   // loader state
   st_t              r_st, w_st_nxt;
   logic             r_ld_d;
   logic             w_ld_rise, w_start, w_wr;
   logic [15:0]      w_hdr;
   logic [7:0]       r_hdr_lo;
   logic [ADDR_W:0]  r_n, r_widx;
   logic [1:0]       r_bidx;
   logic [31:0]      r_word, r_wdata;
   logic [7:0]       r_csum;
   logic             r_we;
   logic [ADDR_W-1:0] r_addr;

   // ---- stage p0/p1: rx synchroniser, byte receiver ----
   always_comb begin
      w_rx_st_nxt = r_rx_st;
      w_cnt_nxt   = r_cnt + 1'b1;
      w_bit_nxt   = r_bit;
      w_sh_nxt    = r_sh;
      w_byte_vld  = 1'b0;
      w_frm_err   = 1'b0;
      case (r_rx_st)
         R_IDLE: begin
            w_cnt_nxt = '0;
            if (!r_rx_p1) w_rx_st_nxt = R_START;
         end
         R_START: if (r_cnt == CNT_W'(HALF - 1)) begin
            // mid start bit: a high line here was only a glitch
            w_cnt_nxt   = '0;
            w_bit_nxt   = '0;
            w_rx_st_nxt = r_rx_p1 ? R_IDLE : R_DATA;
         end
         R_DATA: if (r_cnt == CNT_W'(CPB - 1)) begin
            w_cnt_nxt = '0;
            w_sh_nxt  = {r_rx_p1, r_sh[7:1]};
            w_bit_nxt = r_bit + 1'b1;
            if (r_bit == 3'd7) w_rx_st_nxt = R_STOP;
         end
         R_STOP: if (r_cnt == CNT_W'(CPB - 1)) begin
            w_cnt_nxt   = '0;
            w_rx_st_nxt = R_IDLE;
            w_byte_vld  = r_rx_p1;
            w_frm_err   = ~r_rx_p1;
         end
         default: w_rx_st_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_a) begin
         r_rx_p0    <= 1'b0;
         r_rx_p1    <= 1'b0;
         r_rx_st    <= R_IDLE;
         r_cnt      <= '0;
         r_bit      <= '0;
         r_sh       <= '0;
         r_byte_vld <= 1'b0;
         r_frm_err  <= 1'b0;
      end else begin
         r_rx_p0    <= rx;
         r_rx_p1    <= r_rx_p0;
         r_rx_st    <= w_rx_st_nxt;
         r_cnt      <= w_cnt_nxt;
         r_bit      <= w_bit_nxt;
         r_sh       <= w_sh_nxt;
         r_byte_vld <= w_byte_vld;
         r_frm_err  <= w_frm_err;
      end
   end

   // ---- stage p2: load protocol FSM and memory write ----
   assign w_ld_rise = load_req & ~r_ld_d;
   assign w_start   = w_ld_rise && (r_st == S_IDLE || r_st == S_DONE || r_st == S_ERR);
   assign w_hdr     = {r_sh, r_hdr_lo};

   always_comb begin
      w_st_nxt = r_st;
      w_wr     = 1'b0;
      case (r_st)
         S_IDLE, S_DONE, S_ERR: if (w_start) w_st_nxt = S_HDR0;
         S_HDR0: begin
            if (r_frm_err)       w_st_nxt = S_ERR;
            else if (r_byte_vld) w_st_nxt = S_HDR1;
         end
         S_HDR1: begin
            if (r_frm_err) w_st_nxt = S_ERR;
            else if (r_byte_vld) begin
               if (w_hdr == 16'd0)            w_st_nxt = S_DONE;
               else if ({1'b0, w_hdr} > CAP)  w_st_nxt = S_ERR;
               else                           w_st_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (r_frm_err) w_st_nxt = S_ERR;
            else if (r_byte_vld && r_bidx == 2'd3) begin
               w_wr = 1'b1;
`ifdef UART_CSUM_EN
               if (r_widx == r_n - ONE) w_st_nxt = S_CSUM;
`else
               if (r_widx == r_n - ONE) w_st_nxt = S_DONE;
`endif
            end
         end
`ifdef UART_CSUM_EN
         S_CSUM: begin
            if (r_frm_err)       w_st_nxt = S_ERR;
            else if (r_byte_vld) w_st_nxt = (r_sh == r_csum) ? S_DONE : S_ERR;
         end
`endif
         default: w_st_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_a) begin
         r_st     <= S_IDLE;
         r_ld_d   <= 1'b0;
         r_hdr_lo <= '0;
         r_n      <= '0;
         r_widx   <= '0;
         r_bidx   <= '0;
         r_word   <= '0;
         r_csum   <= '0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
      end else begin
         r_st   <= w_st_nxt;
         r_ld_d <= load_req;
         r_we   <= w_wr;
         if (w_start) begin
            r_widx <= '0;
            r_bidx <= '0;
            r_csum <= '0;
            r_addr <= '0;
         end else if (r_byte_vld) begin
            case (r_st)
               S_HDR0: r_hdr_lo <= r_sh;
               S_HDR1: r_n      <= (ADDR_W + 1)'(w_hdr);
               S_DATA: begin
                  r_word <= {r_sh, r_word[31:8]};
                  r_bidx <= r_bidx + 1'b1;
                  r_csum <= r_csum ^ r_sh;
               end
               default: ;
            endcase
         end
         // strobe issued the cycle after the 4th byte; index advances with it
         if (w_wr) begin
            r_addr  <= r_widx[ADDR_W-1:0];
            r_wdata <= {r_sh, r_word[31:8]};
            r_widx  <= r_widx + ONE;
         end
      end
   end

   assign imem.imem_we    = r_we;
   assign imem.imem_addr  = r_addr;
   assign imem.imem_wdata = r_wdata;
   assign cpu_hold        = (r_st != S_IDLE) && (r_st != S_DONE);
   assign done            = (r_st == S_DONE);
   assign err             = (r_st == S_ERR);
endmodule

// File: tb/tb_uart_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_prog_loader
// Directed and randomized UART loads checked against a byte-level reference
// model of the load protocol (header, words, optional checksum).
// -----------------------------------------------------------------------------
module tb_uart_prog_loader;
   localparam int CLK_HZ = 1_000_000;
   localparam int BAUD   = 100_000;
   localparam int ADDR_W = 4;
   localparam int CPB    = CLK_HZ / BAUD;

   logic clk = 1'b0;
   logic rst_a = 1'b0;
   logic rx = 1'b1;
   logic load_req = 1'b0;
   logic cpu_hold, done, err;

   uart_prog_loader_if #(.ADDR_W(ADDR_W)) imem ();

   uart_prog_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W)) dut (
      .clk      (clk),
      .rst_a    (rst_a),
      .rx       (rx),
      .load_req (load_req),
      .imem     (imem),
      .cpu_hold (cpu_hold),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [7:0]         tx_b[$];
   bit                 tx_ok[$];
   logic [ADDR_W+31:0] got_w[$];
   logic [ADDR_W+31:0] exp_w[$];
   bit                 exp_done, exp_err;

   always @(negedge clk)
      if (imem.imem_we === 1'b1) got_w.push_back({imem.imem_addr, imem.imem_wdata});

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bit_time(input logic v);
      rx = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit ok);
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(b[i]);
      bit_time(ok);
      bit_time(1'b1);
   endtask

   task automatic push(input logic [7:0] b, input bit ok);
      tx_b.push_back(b);
      tx_ok.push_back(ok);
   endtask

   task automatic add_csum();
`ifdef UART_CSUM_EN
      logic [7:0] x;
      x = 8'h00;
      for (int i = 2; i < tx_b.size(); i++) x ^= tx_b[i];
      push(x, 1'b1);
`endif
   endtask

   task automatic build_load(input int n);
      push(8'(n), 1'b1);
      push(8'(n >> 8), 1'b1);
      for (int i = 0; i < 4 * n; i++) push(8'($urandom), 1'b1);
      add_csum();
   endtask

   // Reference: walk the byte stream with the protocol rules.
   task automatic model();
      int n;
      logic [31:0] w;
      logic [7:0]  x;
      exp_w.delete();
      exp_done = 1'b0;
      exp_err  = 1'b0;
      n = 0;
      w = '0;
      x = '0;
      for (int i = 0; i < tx_b.size(); i++) begin
         if (!tx_ok[i]) begin exp_err = 1'b1; return; end
         if (i == 1) begin
            n = int'({tx_b[1], tx_b[0]});
            if (n == 0) begin exp_done = 1'b1; return; end
            if (n > (1 << ADDR_W)) begin exp_err = 1'b1; return; end
         end else if (i >= 2) begin
            int k;
            k = i - 2;
            if (k < 4 * n) begin
               w = w | (32'(tx_b[i]) << (8 * (k % 4)));
               x = x ^ tx_b[i];
               if (k % 4 == 3) begin
                  exp_w.push_back({ADDR_W'(k / 4), w});
                  w = '0;
               end
`ifndef UART_CSUM_EN
               if (k == 4 * n - 1) begin exp_done = 1'b1; return; end
`endif
            end else begin
               exp_done = (tx_b[i] == x);
               exp_err  = !exp_done;
               return;
            end
         end
      end
   endtask

   task automatic run_load(input string tag, input bit pulse);
      got_w.delete();
      if (pulse) begin
         load_req = 1'b1;
         repeat (2) @(negedge clk);
         chk({tag, "_start"}, {done, err, cpu_hold}, 3'b001);
         load_req = 1'b0;
      end
      foreach (tx_b[i]) send_byte(tx_b[i], tx_ok[i]);
      repeat (3) @(negedge clk);
      model();
      chk({tag, "_nwr"}, got_w.size(), exp_w.size());
      foreach (exp_w[i])
         if (i < got_w.size()) chk($sformatf("%s_wr%0d", tag, i), got_w[i], exp_w[i]);
      chk({tag, "_flags"}, {done, err, cpu_hold}, {exp_done, exp_err, ~exp_done});
      tx_b.delete();
      tx_ok.delete();
   endtask

   initial begin
      // reset with rx toggling
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         rx = ~rx;
         chk("rst_outs", {imem.imem_we, done, err, cpu_hold}, 4'b0000);
      end
      rx = 1'b1;
      repeat (3) @(negedge clk);
      rst_a = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_idle", {done, err, cpu_hold}, 3'b000);
      chk("rst_nwr", got_w.size(), 0);

      // N=2 reference image
      push(8'h02, 1); push(8'h00, 1);
      push(8'h78, 1); push(8'h56, 1); push(8'h34, 1); push(8'h12, 1);
      push(8'hEF, 1); push(8'hBE, 1); push(8'hAD, 1); push(8'hDE, 1);
      add_csum();
      run_load("n2", 1'b1);
      chk("n2_w0_const", got_w[0], {4'd0, 32'h12345678});
      chk("n2_w1_const", got_w[1], {4'd1, 32'hDEADBEEF});

      // N=0
      push(8'h00, 1); push(8'h00, 1);
      run_load("n0", 1'b1);

      // N=17 overflow, then restart clears err
      push(8'h11, 1); push(8'h00, 1);
      run_load("ovf", 1'b1);
      got_w.delete();
      load_req = 1'b1;
      repeat (2) @(negedge clk);
      load_req = 1'b0;
      chk("ovf_restart", {done, err, cpu_hold}, 3'b001);

      // glitch on rx while in HDR0, then full-capacity load
      rx = 1'b0;
      repeat (2) @(negedge clk);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      chk("glitch_flags", {done, err, cpu_hold}, 3'b001);
      chk("glitch_nwr", got_w.size(), 0);
      build_load(16);
      run_load("n16", 1'b0);

      // framing error on 3rd data byte
      push(8'h02, 1); push(8'h00, 1);
      push(8'h01, 1); push(8'h02, 1); push(8'h03, 0); push(8'h04, 1);
      push(8'h05, 1); push(8'h06, 1); push(8'h07, 1); push(8'h08, 1);
      run_load("frm", 1'b1);

`ifdef UART_CSUM_EN
      // wrong checksum: words still written, err flagged
      build_load(3);
      tx_b[tx_b.size() - 1] = ~tx_b[tx_b.size() - 1];
      run_load("badcsum", 1'b1);
`endif

      // reset mid-DATA
      got_w.delete();
      load_req = 1'b1;
      repeat (2) @(negedge clk);
      load_req = 1'b0;
      send_byte(8'h02, 1); send_byte(8'h00, 1);
      send_byte(8'h78, 1); send_byte(8'h56, 1);
      chk("mid_hold", cpu_hold, 1'b1);
      rst_a = 1'b0;
      @(negedge clk);
      chk("mid_rst", {imem.imem_we, done, err, cpu_hold}, 4'b0000);
      rst_a = 1'b1;
      send_byte(8'h34, 1); send_byte(8'h12, 1);
      send_byte(8'hEF, 1); send_byte(8'hBE, 1);
      send_byte(8'hAD, 1); send_byte(8'hDE, 1);
      repeat (3) @(negedge clk);
      chk("mid_nwr", got_w.size(), 0);
      chk("mid_idle", {done, err, cpu_hold}, 3'b000);

      // randomized loads
      for (int r = 0; r < 3; r++) begin
         build_load(int'($urandom_range(1, 16)));
         run_load($sformatf("rnd%0d", r), 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
